seq_ctrl: RTL
=============

// Module: seq_ctrl
// PURPOSE
//   Sequencing controller for the 5-bit beat counter. It accepts a job through a
//   valid/ready handshake, clears the counter, and enables it for cfg_len+1 beats.
//   It watches cnt_o to detect the last beat, runs a fixed drain, then pulses done.
//   Drives cnt_en / cnt_rst_n of the counter; run_valid/run_last feed the datapath.
// PARAMETERS
//   CNT_W      5   width of cfg_len and of the counter value cnt_o
//   DRAIN_CYC  2   cycles spent in DRAIN after the last beat (legal range 1..15)
// PORTS
//   seq_clk      in   1      single clock, rising edge
//   seq_rst_n    in   1      asynchronous active-low reset
//   start_valid  in   1      job request
//   start_ready  out  1      controller can accept a job (IDLE only)
//   cfg_len      in   CNT_W  index of last beat; beats = cfg_len+1; sampled on accept
//   stall        in   1      pause the beat stream (RUN only)
//   abort        in   1      cancel the current job
//   cnt_o        in   CNT_W  current counter value
//   cnt_en       out  1      counter increment enable
//   cnt_rst_n    out  1      counter synchronous clear, active-low
//   run_valid    out  1      a beat is issued this cycle
//   run_last     out  1      the issued beat is the final beat
//   busy         out  1      state != IDLE
//   done         out  1      one-cycle completion pulse
// BEHAVIOUR
//   - Reset (async, seq_rst_n=0): state=IDLE, len_q=0, drain_q=0. Outputs: start_ready=1,
//     cnt_en=0, cnt_rst_n=1, run_valid=0, run_last=0, busy=0, done=0.
//     Reset mid-job discards the job immediately, with no done pulse.
//   - States: IDLE, CLEAR, RUN, DRAIN, DONE. All outputs decode from registered state,
//     len_q, cnt_o and stall, with no combinational path from start_valid.
//   - IDLE: start_ready=1. On start_valid&&start_ready: len_q<=cfg_len, go to CLEAR.
//     abort is ignored in IDLE.
//   - CLEAR (1 cycle): cnt_rst_n=0, cnt_en=0, so cnt_o==0 in the first RUN cycle.
//   - RUN: cnt_en=run_valid=!stall. run_last=run_valid && (cnt_o==len_q).
//     On run_last go to DRAIN with drain_q<=DRAIN_CYC-1. A stall holds state and cnt_o.
//   - DRAIN: drain_q decrements each cycle. Go to DONE when drain_q==0.
//   - DONE (1 cycle): done=1, then IDLE. start_ready rises the cycle after done.
//   - Latency: accept at edge k -> CLEAR cycle k+1 -> first beat cycle k+2.
//     With no stalls, done is high in cycle k+2+(cfg_len+1)+DRAIN_CYC.
//   - Abort in CLEAR/RUN/DRAIN/DONE: next state is IDLE and cnt_rst_n=0 in that cycle.
//     No run_valid and no done in that cycle. Abort has priority over stall and run_last.
//   - cfg_len=0 gives a single beat, with run_last on the first RUN beat.
//   - cfg_len=2^CNT_W-1: on the last beat the counter wraps to 0. This is harmless,
//     because the controller has already left RUN.
//   - The comparison is exact-width (CNT_W bits) and has no carry.
//     cnt_o is never compared outside RUN.
// STRUCTURE
//   - Package seq_pkg: typedef enum logic [2:0] seq_state_e {IDLE,CLEAR,RUN,DRAIN,DONE};
//     localparam CNT_W_DEF=5.
//   - Single module: drain_q is an inline 4-bit down-counter, with no sub-module.
//   - At top level, cnt_en/cnt_rst_n/cnt_o connect to the existing counter instance,
//     and its clock ties to seq_clk.
// TESTING
//   1 Reset: hold seq_rst_n=0 -> start_ready=1, busy=0, cnt_en=0, cnt_rst_n=1, done=0.
//   2 cfg_len=3, no stall, DRAIN_CYC=2, accept at cycle 0 -> CLEAR at cycle 1.
//     run_valid in cycles 2-5 with cnt_o 0..3, run_last at cycle 5, done at cycle 8.
//   3 cfg_len=3, stall=1 in cycles 3-4 -> cnt_o holds at 1 and run_valid=0 in those cycles.
//     run_last moves to cycle 7 and done to cycle 10.
//   4 cfg_len=0 -> one beat with run_valid=run_last=1 at cycle 2, done at cycle 5.
//     cfg_len=31 -> 32 beats; the counter wraps to 0 after the last beat, done at cycle 36.
//   5 abort in RUN at cnt_o=2 -> next cycle IDLE with cnt_rst_n=0.
//     No done; the next job starts with cnt_o=0. Abort+stall in the same cycle: abort wins.
//   6 Async reset pulse mid-DRAIN -> outputs return to reset values without a clock edge.
//     No done. start_valid held high during DONE is accepted only after IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the beat-sequencing controller.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/seq_ctrl.sv
// Beat sequencer: accepts a job, clears and enables the
// external beat counter for cfg_len+1 beats, drains, pulses done.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = 2
) (
  input  logic             seq_clk,
  input  logic             seq_rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             stall,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_o,
  output logic             cnt_en,
  output logic             cnt_rst_n,
  output logic             run_valid,
  output logic             run_last,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

  seq_state_e       r_state;
  seq_state_e       w_nxt;
  logic [CNT_W-1:0] r_len;
  logic [3:0]       r_drain;
  logic             w_accept;
  logic             w_to_drain;

  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) r_len <= cfg_len;
      if (w_to_drain) begin
        r_drain <= DRAIN_INIT;
      end else if (r_state == DRAIN && r_drain != '0) begin
        r_drain <= r_drain - 4'd1;
      end
    end
  end

  always_comb begin
    w_nxt       = r_state;
    start_ready = 1'b0;
    cnt_en      = 1'b0;
    cnt_rst_n   = 1'b1;
    run_valid   = 1'b0;
    run_last    = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_to_drain  = 1'b0;
    unique case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_accept = 1'b1;
          w_nxt    = CLEAR;
        end
      end
      CLEAR: begin
        cnt_rst_n = 1'b0;
        w_nxt     = RUN;
      end
      RUN: begin
        run_valid = !stall;
        cnt_en    = !stall;
        run_last  = !stall && (cnt_o == r_len);
        if (run_last) begin
          w_to_drain = 1'b1;
          w_nxt      = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain == '0) w_nxt = DONE;
      end
      DONE: begin
        done  = 1'b1;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    // Abort overrides everything, including stall and the last beat
    if (abort && r_state != IDLE) begin
      w_nxt      = IDLE;
      cnt_rst_n  = 1'b0;
      cnt_en     = 1'b0;
      run_valid  = 1'b0;
      run_last   = 1'b0;
      done       = 1'b0;
      w_to_drain = 1'b0;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
